// File: rtl/mcht_dec.sv
// -----------------------------------------------------------------------------
// mcht_dec -- Manchester line decoder, receive-side partner of the team's
// Manchester encoder. One CLK_25M cycle per half-bit.
//
// Line format: idle 1, preamble 0 then 1, then pMSG_LEN bits LSB first, each
// sent as (~bit, bit). A half-bit pair with equal halves, or a missing
// preamble high, aborts the frame with a one-cycle ERR. The decoder then waits
// for three consecutive idle highs before it hunts for a new preamble.
//
// Optional build macro: MCHT_DEC_SYNC_EN
//   defined   : RXD passes a 2-flop synchroniser ahead of the sample flop
//               (3 cycles total; use when RXD is an off-chip pin)
//   undefined : single sample flop (on-chip loopback from the encoder)
//
// Ports:
//   CLK_25M  in   system clock, 25 MHz
//   RST_N    in   asynchronous active-low reset
//   RXD      in   Manchester line, idle high
//   MSG      out  [pMSG_LEN] last correctly received message, bit 0 first
//   MSG_VLD  out  one-cycle pulse, MSG updated this cycle
//   ERR      out  one-cycle pulse, frame aborted
//   BUSY     out  high whenever the decoder is not idle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mcht_dec #(
  parameter int unsigned pMSG_LEN = 16
) (
  input  logic                CLK_25M,
  input  logic                RST_N,
  input  logic                RXD,
  output logic [pMSG_LEN-1:0] MSG,
  output logic                MSG_VLD,
  output logic                ERR,
  output logic                BUSY
);

  localparam int unsigned IDX_W = $clog2(pMSG_LEN);
  localparam int unsigned RCNT_W = 2;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(pMSG_LEN - 1);
  localparam logic [RCNT_W-1:0] RCNT_DONE = RCNT_W'(2);

  localparam logic [2:0] eIDLE  = 3'd0;
  localparam logic [2:0] ePRE   = 3'd1;
  localparam logic [2:0] eH0    = 3'd2;
  localparam logic [2:0] eH1    = 3'd3;
  localparam logic [2:0] eRECOV = 3'd4;

  // Registered line sample; every decode decision looks only at s.
  logic s;

`ifdef MCHT_DEC_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchroniser plus sample flop, all resetting to the idle level.
  always_ff @(posedge CLK_25M or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= 2'b11;
      s      <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], RXD};
      s      <= sync_q[1];
    end
  end
`else
  // Single sample flop for on-chip loopback.
  always_ff @(posedge CLK_25M or negedge RST_N) begin
    if (!RST_N) begin
      s <= 1'b1;
    end else begin
      s <= RXD;
    end
  end
`endif

  logic [2:0]          cur_st;
  logic [2:0]          nxt_st;
  logic                h0;
  logic                nxt_h0;
  logic [IDX_W-1:0]    bit_idx;
  logic [IDX_W-1:0]    nxt_idx;
  logic [pMSG_LEN-1:0] shreg;
  logic [pMSG_LEN-1:0] nxt_shreg;
  logic [RCNT_W-1:0]   rcnt;
  logic [RCNT_W-1:0]   nxt_rcnt;
  logic [pMSG_LEN-1:0] nxt_msg;
  logic                nxt_vld;
  logic                nxt_err;

  // State and datapath registers; outputs are registered copies of the
  // next-state decisions so they land one clock after the deciding sample.
  always_ff @(posedge CLK_25M or negedge RST_N) begin
    if (!RST_N) begin
      cur_st  <= eIDLE;
      h0      <= 1'b0;
      bit_idx <= '0;
      shreg   <= '0;
      rcnt    <= '0;
      MSG     <= '0;
      MSG_VLD <= 1'b0;
      ERR     <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      cur_st  <= nxt_st;
      h0      <= nxt_h0;
      bit_idx <= nxt_idx;
      shreg   <= nxt_shreg;
      rcnt    <= nxt_rcnt;
      MSG     <= nxt_msg;
      MSG_VLD <= nxt_vld;
      ERR     <= nxt_err;
      BUSY    <= (nxt_st != eIDLE);
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    nxt_st    = cur_st;
    nxt_h0    = h0;
    nxt_idx   = bit_idx;
    nxt_shreg = shreg;
    nxt_rcnt  = rcnt;
    nxt_msg   = MSG;
    nxt_vld   = 1'b0;
    nxt_err   = 1'b0;

    case (cur_st)
      eIDLE: begin
        nxt_idx = '0;
        if (!s) begin
          nxt_st = ePRE;
        end
      end

      ePRE: begin
        if (s) begin
          nxt_st = eH0;
        end else begin
          nxt_st   = eRECOV;
          nxt_err  = 1'b1;
          nxt_idx  = '0;
          nxt_rcnt = '0;
        end
      end

      eH0: begin
        nxt_h0 = s;
        nxt_st = eH1;
      end

      eH1: begin
        if (h0 == s) begin
          // Equal halves cannot be a valid Manchester symbol.
          nxt_st   = eRECOV;
          nxt_err  = 1'b1;
          nxt_idx  = '0;
          nxt_rcnt = '0;
        end else begin
          nxt_shreg[bit_idx] = s;
          if (bit_idx == LAST_IDX) begin
            nxt_st  = eIDLE;
            nxt_msg = nxt_shreg;
            nxt_vld = 1'b1;
            nxt_idx = '0;
          end else begin
            nxt_idx = bit_idx + IDX_W'(1);
            nxt_st  = eH0;
          end
        end
      end

      eRECOV: begin
        // A run of three highs cannot occur inside a frame, so it marks idle.
        if (s) begin
          if (rcnt == RCNT_DONE) begin
            nxt_st   = eIDLE;
            nxt_rcnt = '0;
          end else begin
            nxt_rcnt = rcnt + RCNT_W'(1);
          end
        end else begin
          nxt_rcnt = '0;
        end
      end

      default: begin
        nxt_st  = eIDLE;
        nxt_idx = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mcht_dec.sv
// -----------------------------------------------------------------------------
// tb_mcht_dec -- self-checking bench for mcht_dec. A behavioural encoder task
// drives RXD one half-bit per clock; expected results come from the frame
// contents the bench chose (good frames deliver their word, corrupted frames
// deliver nothing and raise one ERR).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mcht_dec;

  localparam int unsigned LEN = 16;
`ifdef MCHT_DEC_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic           CLK_25M = 1'b0;
  logic           RST_N   = 1'b0;
  logic           RXD     = 1'b1;
  logic [LEN-1:0] MSG;
  logic           MSG_VLD;
  logic           ERR;
  logic           BUSY;

  mcht_dec #(.pMSG_LEN(LEN)) dut (
    .CLK_25M (CLK_25M),
    .RST_N   (RST_N),
    .RXD     (RXD),
    .MSG     (MSG),
    .MSG_VLD (MSG_VLD),
    .ERR     (ERR),
    .BUSY    (BUSY)
  );

  always #20 CLK_25M = ~CLK_25M;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int overlap = 0;
  int vld_cyc = 0;
  int t_pre = 0;
  logic [LEN-1:0] msg_q[$];

  always @(posedge CLK_25M) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge CLK_25M) begin
    if (MSG_VLD) begin
      vld_cnt = vld_cnt + 1;
      vld_cyc = cyc;
      msg_q.push_back(MSG);
    end
    if (ERR) err_cnt = err_cnt + 1;
    if (MSG_VLD && ERR) overlap = overlap + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required<25000", cyc);
    $fatal(1);
  end

  task automatic half(input logic b);
    @(negedge CLK_25M);
    RXD = b;
  endtask

  task automatic idle(input int n);
    repeat (n) half(1'b1);
  endtask

  // Encoder model; bad>=0 makes that bit's second half repeat the first half.
  task automatic send_frame(input logic [LEN-1:0] m, input int bad);
    half(1'b0);
    t_pre = cyc;
    half(1'b1);
    for (int i = 0; i < int'(LEN); i++) begin
      half(~m[i]);
      if (i == bad) half(~m[i]);
      else          half(m[i]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK_25M);
    checks++; if (MSG !== 16'h0000) $display("FAIL reset_msg got=%h exp=0000", MSG); else passes++;
    checks++; if (MSG_VLD !== 1'b0) $display("FAIL reset_vld got=%b exp=0", MSG_VLD); else passes++;
    checks++; if (ERR !== 1'b0) $display("FAIL reset_err got=%b exp=0", ERR); else passes++;
    checks++; if (BUSY !== 1'b0) $display("FAIL reset_busy got=%b exp=0", BUSY); else passes++;
    @(negedge CLK_25M);
    RST_N = 1'b1;
    idle(4);
    checks++; if (BUSY !== 1'b0) $display("FAIL idle_busy got=%b exp=0", BUSY); else passes++;
  endtask

  task automatic test_loopback();
    int v0 = vld_cnt;
    int e0 = err_cnt;
    send_frame(16'hA5C3, -1);
    idle(4 + EXTRA);
    checks++; if (vld_cnt - v0 !== 1) $display("FAIL loop_vld_count got=%0d exp=1", vld_cnt - v0); else passes++;
    checks++; if (MSG !== 16'hA5C3) $display("FAIL loop_msg got=%h exp=a5c3", MSG); else passes++;
    checks++; if (err_cnt - e0 !== 0) $display("FAIL loop_err got=%0d exp=0", err_cnt - e0); else passes++;
    checks++;
    if (vld_cyc - t_pre !== 2 * LEN + 3 + EXTRA)
      $display("FAIL loop_latency got=%0d exp=%0d", vld_cyc - t_pre, 2 * LEN + 3 + EXTRA);
    else passes++;
  endtask

  task automatic test_corrupt();
    int v0 = vld_cnt;
    int e0 = err_cnt;
    send_frame(16'h5A5A, 5);
    idle(6 + EXTRA);
    checks++; if (err_cnt - e0 !== 1) $display("FAIL corrupt_err got=%0d exp=1", err_cnt - e0); else passes++;
    checks++; if (vld_cnt - v0 !== 0) $display("FAIL corrupt_vld got=%0d exp=0", vld_cnt - v0); else passes++;
    checks++; if (MSG !== 16'hA5C3) $display("FAIL corrupt_msg_kept got=%h exp=a5c3", MSG); else passes++;
    checks++; if (BUSY !== 1'b0) $display("FAIL corrupt_recovered got=%b exp=0", BUSY); else passes++;
    send_frame(16'h1234, -1);
    idle(4 + EXTRA);
    checks++; if (MSG !== 16'h1234) $display("FAIL corrupt_next_msg got=%h exp=1234", MSG); else passes++;
    checks++; if (vld_cnt - v0 !== 1) $display("FAIL corrupt_next_vld got=%0d exp=1", vld_cnt - v0); else passes++;
  endtask

  task automatic test_back_to_back();
    int v0 = vld_cnt;
    int e0 = err_cnt;
    msg_q.delete();
    send_frame(16'h0001, -1);
    send_frame(16'hFFFE, -1);
    idle(4 + EXTRA);
    checks++; if (vld_cnt - v0 !== 2) $display("FAIL b2b_vld_count got=%0d exp=2", vld_cnt - v0); else passes++;
    checks++; if (err_cnt - e0 !== 0) $display("FAIL b2b_err got=%0d exp=0", err_cnt - e0); else passes++;
    checks++;
    if (msg_q.size() != 2) $display("FAIL b2b_queue_size got=%0d exp=2", msg_q.size());
    else if (msg_q[0] !== 16'h0001 || msg_q[1] !== 16'hFFFE)
      $display("FAIL b2b_values got=%h,%h exp=0001,fffe", msg_q[0], msg_q[1]);
    else passes++;
  endtask

  task automatic test_preamble();
    int v0 = vld_cnt;
    int e0 = err_cnt;
    logic [LEN-1:0] m0 = MSG;
    logic [7:0] seq = 8'b1111_0011;
    for (int i = 0; i < 8; i++) half(seq[i]);
    idle(2 + EXTRA);
    checks++; if (err_cnt - e0 !== 1) $display("FAIL pre_err got=%0d exp=1", err_cnt - e0); else passes++;
    checks++; if (vld_cnt - v0 !== 0) $display("FAIL pre_vld got=%0d exp=0", vld_cnt - v0); else passes++;
    checks++; if (BUSY !== 1'b0) $display("FAIL pre_busy got=%b exp=0", BUSY); else passes++;
    checks++; if (MSG !== m0) $display("FAIL pre_msg got=%h exp=%h", MSG, m0); else passes++;
  endtask

  task automatic test_glitch();
    int v0 = vld_cnt;
    int e0 = err_cnt;
    logic busy_hi = 1'b0;
    int done = -1;
    half(1'b0);
    for (int i = 0; i < 12 + EXTRA; i++) begin
      half(1'b1);
      if (BUSY) busy_hi = 1'b1;
      else if (busy_hi && done < 0) done = i;
    end
    checks++; if (busy_hi !== 1'b1) $display("FAIL glitch_busy_seen got=%b exp=1", busy_hi); else passes++;
    checks++; if (done < 0) $display("FAIL glitch_busy_return got=%0d exp>=0", done); else passes++;
    checks++; if (err_cnt - e0 !== 1) $display("FAIL glitch_err got=%0d exp=1", err_cnt - e0); else passes++;
    checks++; if (vld_cnt - v0 !== 0) $display("FAIL glitch_vld got=%0d exp=0", vld_cnt - v0); else passes++;
  endtask

  task automatic test_reset_midframe();
    logic [LEN-1:0] part = 16'h0F0F;
    int v0;
    int e0;
    half(1'b0);
    half(1'b1);
    for (int i = 0; i < 7; i++) begin
      half(~part[i]);
      half(part[i]);
    end
    checks++; if (BUSY !== 1'b1) $display("FAIL mid_busy_before got=%b exp=1", BUSY); else passes++;
    #5 RST_N = 1'b0;
    #1;
    checks++; if (MSG !== 16'h0000) $display("FAIL mid_rst_msg got=%h exp=0000", MSG); else passes++;
    checks++; if (MSG_VLD !== 1'b0 || ERR !== 1'b0) $display("FAIL mid_rst_pulses got=%b%b exp=00", MSG_VLD, ERR); else passes++;
    checks++; if (BUSY !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", BUSY); else passes++;
    half(1'b1);
    @(negedge CLK_25M);
    RST_N = 1'b1;
    idle(2);
    v0 = vld_cnt;
    e0 = err_cnt;
    send_frame(16'hBEEF, -1);
    idle(4 + EXTRA);
    checks++; if (MSG !== 16'hBEEF) $display("FAIL mid_after_msg got=%h exp=beef", MSG); else passes++;
    checks++; if (vld_cnt - v0 !== 1 || err_cnt - e0 !== 0)
      $display("FAIL mid_after_counts got=vld%0d,err%0d exp=vld1,err0", vld_cnt - v0, err_cnt - e0);
    else passes++;
  endtask

  task automatic test_random();
    logic [LEN-1:0] exp_q[$];
    logic [LEN-1:0] model_msg = MSG;
    logic [LEN-1:0] m;
    int exp_err = 0;
    int e0 = err_cnt;
    int bad;
    msg_q.delete();
    for (int f = 0; f < 40; f++) begin
      m = LEN'($urandom());
      bad = ($urandom_range(3) == 0) ? int'($urandom_range(LEN - 1)) : -1;
      send_frame(m, bad);
      if (bad < 0) begin
        exp_q.push_back(m);
        model_msg = m;
        idle(int'($urandom_range(3)));
      end else begin
        exp_err++;
        idle(4 + int'($urandom_range(3)));
      end
    end
    idle(6 + EXTRA);
    checks++; if (err_cnt - e0 !== exp_err) $display("FAIL rnd_err got=%0d exp=%0d", err_cnt - e0, exp_err); else passes++;
    checks++; if (msg_q.size() != exp_q.size()) $display("FAIL rnd_count got=%0d exp=%0d", msg_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < msg_q.size(); i++) begin
      checks++;
      if (msg_q[i] !== exp_q[i]) $display("FAIL rnd_msg[%0d] got=%h exp=%h", i, msg_q[i], exp_q[i]);
      else passes++;
    end
    checks++; if (MSG !== model_msg) $display("FAIL rnd_final_msg got=%h exp=%h", MSG, model_msg); else passes++;
    checks++; if (overlap !== 0) $display("FAIL vld_err_overlap got=%0d exp=0", overlap); else passes++;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_corrupt();
    test_back_to_back();
    test_preamble();
    test_glitch();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mcht_dec.md
Name: mcht_dec

Overview:
- Manchester decoder; the receive-side counterpart of the team's Manchester encoder.
- Consumes the single-wire line produced by the encoder (TXD) and recovers the pMSG_LEN-bit message.
- Runs in the same CLK_25M domain at one half-bit per clock. It is used for on-board loopback and for link self-test.
- Flags malformed frames and resynchronises to line idle on its own.

Parameters:
- pMSG_LEN, 16, message width in bits; must be at least 2. The bit counter is $clog2(pMSG_LEN) wide.

Ports:
- CLK_25M  input  1  system clock, 25 MHz.
- RST_N  input  1  asynchronous, active-low reset.
- RXD  input  1  Manchester line. Idle high.
- MSG  output  pMSG_LEN  last correctly received message; bit 0 is the first bit received.
- MSG_VLD  output  1  one-cycle pulse; MSG was updated this cycle.
- ERR  output  1  one-cycle pulse; frame aborted.
- BUSY  output  1  high while in any state other than eIDLE.

Behaviour:
- Line format, one clock per half-bit:
  - idle = 1;
  - preamble = 0 then 1;
  - then pMSG_LEN bits, LSB first. Each bit is sent as first half = ~bit, second half = bit;
  - line returns to 1 after the frame.
- Maximum run of equal levels inside a frame is 2.
- All decoding uses s, the registered RXD. s is RXD delayed by 1 flop, or by 3 flops when the optional feature is enabled.
- State machine (cur_st/nxt_st, registered state):
  - eIDLE: s==0 -> ePRE; otherwise stay.
  - ePRE: s==1 -> eH0; s==0 -> eRECOV with ERR.
  - eH0: latch h0<=s -> eH1.
  - eH1:
    - if h0==s -> eRECOV with ERR;
    - otherwise shift s into the shift register at position bit_idx;
    - if bit_idx==pMSG_LEN-1 -> eIDLE with MSG<=assembled word and MSG_VLD;
    - otherwise bit_idx+1 -> eH0.
  - eRECOV: count consecutive s==1 samples. After 3 in a row -> eIDLE. Any 0 clears the count.
- bit_idx is cleared in eIDLE and on every ERR.
- MSG_VLD and ERR are registered. They assert in the clock after the deciding sample.
- Latency: MSG_VLD rises 1 clock after the second half of the last bit is sampled into s.
- MSG changes only on a good frame. An aborted frame never alters MSG.
- The shift register is internal. Partial contents are never visible.
- Back-to-back frames: decoder is in eIDLE the cycle after MSG_VLD. It accepts a preamble low on the next sample, with no required gap.
- A glitch low in idle produces a preamble fail or a half-bit mismatch, then ERR, then recovery. Nothing is delivered on MSG.
- Reset (asynchronous, any time, including mid-frame):
  - cur_st=eIDLE, bit_idx=0, shift register=0, MSG=0;
  - MSG_VLD=0, ERR=0, BUSY=0;
  - sync flops=1 (idle level).
- MSG_VLD and ERR are never high in the same cycle.

Optional Feature:
- Macro MCHT_DEC_SYNC_EN.
- Defined:
  - RXD passes through a 2-flop synchroniser, reset to 1, ahead of the sample flop. Total delay is 3 clocks.
  - Required when RXD comes from an off-chip pin.
  - All latencies above grow by 2 clocks.
- Undefined:
  - single sample flop only. Intended for on-chip loopback from the encoder.
- Decode logic is identical in both builds.

Test Plan:
- Encoder loopback, MSG=16'hA5C3, SOF pulsed once -> MSG_VLD single pulse, MSG==16'hA5C3, ERR never high. MSG_VLD lands 2*16+2 clocks after the preamble low enters s, ±1 per build.
- Two frames back to back, 16'h0001 then 16'hFFFE, second SOF issued as soon as encoder DONE -> two MSG_VLD pulses with those exact values, no ERR.
- Corrupt frame: force bit 5 second half equal to first half (e.g. 0,0) -> ERR one cycle, no MSG_VLD, MSG keeps previous value (16'hA5C3). Decoder returns to eIDLE after 3 idle highs, then decodes a following 16'h1234 correctly.
- Preamble error: RXD 1,1,0,0,1,1,1,1 -> ERR once, BUSY drops after 3 consecutive highs, MSG unchanged.
- Single-cycle low glitch on idle line -> exactly one ERR, no MSG_VLD, BUSY returns low within 6 clocks.
- Assert RST_N low mid-frame after 7 bits -> all outputs 0 immediately. After release, a fresh 16'hBEEF frame decodes correctly with no stale bits.
